// File: rtl/addr_add_sequencer_if.sv
// Request/response and shared-Adder signals of the effective-address sequencer.
// slave = sequencer side, master = requester plus Adder side.
interface addr_add_sequencer_if #(
    parameter int NrOfBits = 8
);
    logic                    Start;
    logic [2*NrOfBits-1:0]   BaseAddr;
    logic [NrOfBits-1:0]     Offset;
    logic                    Busy;
    logic                    Done;
    logic                    PageCross;
    logic [2*NrOfBits-1:0]   Result;
    logic [NrOfBits-1:0]     AdderDataA;
    logic [NrOfBits-1:0]     AdderDataB;
    logic                    AdderCarryIn;
    logic [NrOfBits-1:0]     AdderResult;
    logic                    AdderCarryOut;

    modport slave (
        input  Start, BaseAddr, Offset, AdderResult, AdderCarryOut,
        output Busy, Done, PageCross, Result, AdderDataA, AdderDataB, AdderCarryIn
    );

    modport master (
        output Start, BaseAddr, Offset, AdderResult, AdderCarryOut,
        input  Busy, Done, PageCross, Result, AdderDataA, AdderDataB, AdderCarryIn
    );
endinterface

// File: rtl/addr_add_sequencer.sv
// Forms BaseAddr + Offset on the shared 8-bit Adder; high-byte fix-up only on page cross.
// Optional feature macro: SIGNED_OFFSET_EN (two's-complement Offset for relative branches).
module addr_add_sequencer #(
    parameter int NrOfBits = 8
) (
    input  logic                 Clock,
    input  logic                 nReset,
    addr_add_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                state, nextState;
    logic [2*NrOfBits-1:0] baseReg;
    logic [NrOfBits-1:0]   offReg;
    logic [2*NrOfBits-1:0] resultReg;
    logic                  pageCrossReg;
    logic                  neg;
    logic                  fix;
    logic                  accept;

`ifdef SIGNED_OFFSET_EN
    assign neg = offReg[NrOfBits-1];
`else
    assign neg = 1'b0;
`endif

    assign accept = bus.Start && (state == IDLE || state == DONE);
    assign fix    = bus.AdderCarryOut ^ neg;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState        = state;
        bus.AdderDataA   = '0;
        bus.AdderDataB   = '0;
        bus.AdderCarryIn = 1'b0;
        case (state)
            IDLE: if (accept) nextState = LOW;
            LOW: begin
                bus.AdderDataA = baseReg[NrOfBits-1:0];
                bus.AdderDataB = offReg;
                nextState      = fix ? HIGH : DONE;
            end
            HIGH: begin
                bus.AdderDataA = baseReg[2*NrOfBits-1:NrOfBits];
`ifdef SIGNED_OFFSET_EN
                // HIGH only runs when carry and sign disagree, so sign alone picks inc vs dec
                bus.AdderDataB   = neg ? '1 : '0;
                bus.AdderCarryIn = ~neg;
`else
                bus.AdderCarryIn = 1'b1;
`endif
                nextState = DONE;
            end
            DONE: nextState = accept ? LOW : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            baseReg      <= '0;
            offReg       <= '0;
            resultReg    <= '0;
            pageCrossReg <= 1'b0;
        end else begin
            if (accept) begin
                baseReg      <= bus.BaseAddr;
                offReg       <= bus.Offset;
                pageCrossReg <= 1'b0;
            end
            if (state == LOW) begin
                resultReg[NrOfBits-1:0] <= bus.AdderResult;
                if (fix) pageCrossReg <= 1'b1;
                else     resultReg[2*NrOfBits-1:NrOfBits] <= baseReg[2*NrOfBits-1:NrOfBits];
            end
            // High-byte carry-out is dropped: the address wraps modulo 2^16
            if (state == HIGH)
                resultReg[2*NrOfBits-1:NrOfBits] <= bus.AdderResult;
        end
    end

    assign bus.Busy      = (state == LOW) || (state == HIGH);
    assign bus.Done      = (state == DONE);
    assign bus.PageCross = pageCrossReg;
    assign bus.Result    = resultReg;
endmodule

// File: tb/tb_addr_add_sequencer.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on Done.
module tb_addr_add_sequencer;
    localparam int N = 8;

    typedef struct {
        logic [15:0] res;
        logic        pc;
        int          doneCyc;
    } exp_t;

    logic Clock = 1'b0;
    logic nReset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    addr_add_sequencer_if #(.NrOfBits(N)) bus ();

    addr_add_sequencer #(.NrOfBits(N)) dut (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (bus)
    );

    // Behavioural 8-bit Adder
    assign {bus.AdderCarryOut, bus.AdderResult} =
        {1'b0, bus.AdderDataA} + {1'b0, bus.AdderDataB} + {8'd0, bus.AdderCarryIn};

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (bus.Done) begin
            if (expQ.size() == 0) begin
                chk("unexpected Done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("Result", {16'd0, bus.Result}, {16'd0, e.res});
                chk("PageCross", {31'd0, bus.PageCross}, {31'd0, e.pc});
                chk("Done cycle", cyc, e.doneCyc);
            end
        end
    end

    // Drive Start for one sampling edge; returns the edge count of that edge (edge 0)
    task automatic issue(input logic [15:0] base, input logic [7:0] off, output int e0);
        bus.Start    = 1'b1;
        bus.BaseAddr = base;
        bus.Offset   = off;
        @(posedge Clock); #1;
        e0 = cyc;
        bus.Start = 1'b0;
    endtask

    // lat is the spec cycle number where Done is high (2 or 3)
    task automatic req(input logic [15:0] base, input logic [7:0] off,
                       input logic [15:0] res, input logic pc, input int lat);
        int e0;
        issue(base, off, e0);
        expQ.push_back('{res, pc, e0 + lat - 1});
        repeat (lat + 1) @(posedge Clock);
        #1;
    endtask

    initial begin
        int e0;
        bus.Start    = 1'b0;
        bus.BaseAddr = '0;
        bus.Offset   = '0;
        #12;
        chk("reset Busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset Done", {31'd0, bus.Done}, 32'd0);
        chk("reset PageCross", {31'd0, bus.PageCross}, 32'd0);
        chk("reset Result", {16'd0, bus.Result}, 32'd0);
        chk("reset Adder", {15'd0, bus.AdderDataA, bus.AdderDataB, bus.AdderCarryIn}, 32'd0);
        @(posedge Clock); #1;
        nReset = 1'b1;
        @(posedge Clock); #1;

        // No page cross, Busy for exactly one cycle
        issue(16'h12F0, 8'h05, e0);
        expQ.push_back('{16'h12F5, 1'b0, e0 + 1});
        chk("Busy in LOW", {31'd0, bus.Busy}, 32'd1);
        chk("LOW Adder", {15'd0, bus.AdderDataA, bus.AdderDataB, bus.AdderCarryIn},
            {15'd0, 8'hF0, 8'h05, 1'b0});
        @(posedge Clock); #1;
        chk("Busy in DONE", {31'd0, bus.Busy}, 32'd0);
        chk("Adder idle in DONE", {15'd0, bus.AdderDataA, bus.AdderDataB, bus.AdderCarryIn}, 32'd0);
        repeat (2) @(posedge Clock); #1;

        // Page cross, HIGH state increments high byte
        issue(16'h12F0, 8'h20, e0);
        expQ.push_back('{16'h1310, 1'b1, e0 + 2});
        @(posedge Clock); #1;
        chk("HIGH Adder inc", {15'd0, bus.AdderDataA, bus.AdderDataB, bus.AdderCarryIn},
            {15'd0, 8'h12, 8'h00, 1'b1});
        chk("Busy in HIGH", {31'd0, bus.Busy}, 32'd1);
        repeat (3) @(posedge Clock); #1;

        req(16'hFFF0, 8'h20, 16'h0010, 1'b1, 3);

`ifdef SIGNED_OFFSET_EN
        issue(16'h1305, 8'hF0, e0);
        expQ.push_back('{16'h12F5, 1'b1, e0 + 2});
        @(posedge Clock); #1;
        chk("HIGH Adder dec", {15'd0, bus.AdderDataA, bus.AdderDataB, bus.AdderCarryIn},
            {15'd0, 8'h13, 8'hFF, 1'b0});
        repeat (3) @(posedge Clock); #1;
        req(16'h1320, 8'hF0, 16'h1310, 1'b0, 2);
`else
        req(16'h1305, 8'hF0, 16'h13F5, 1'b0, 2);
        req(16'h1320, 8'hF0, 16'h1410, 1'b1, 3);
`endif

        // Start held: second request accepted in the DONE cycle
        bus.Start    = 1'b1;
        bus.BaseAddr = 16'h1200;
        bus.Offset   = 8'h10;
        @(posedge Clock); #1;
        e0 = cyc;
        expQ.push_back('{16'h1210, 1'b0, e0 + 1});
        bus.BaseAddr = 16'h12F0;
        bus.Offset   = 8'h20;
        expQ.push_back('{16'h1310, 1'b1, e0 + 4});
        @(posedge Clock); @(posedge Clock); #1;
        bus.Start = 1'b0;
        chk("back-to-back Busy", {31'd0, bus.Busy}, 32'd1);
        repeat (4) @(posedge Clock); #1;

        // Start pulsed in LOW is ignored
        issue(16'h12F0, 8'h05, e0);
        expQ.push_back('{16'h12F5, 1'b0, e0 + 1});
        bus.Start    = 1'b1;
        bus.BaseAddr = 16'h4000;
        bus.Offset   = 8'h80;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        @(posedge Clock); #1;
        chk("idle after ignored Start", {31'd0, bus.Busy}, 32'd0);
        chk("Result after ignored Start", {16'd0, bus.Result}, 32'h12F5);
        repeat (2) @(posedge Clock); #1;

        // Reset during HIGH abandons the sequence
        issue(16'h12F0, 8'h20, e0);
        @(posedge Clock); #1;
        nReset = 1'b0;
        #1;
        chk("async reset Busy", {31'd0, bus.Busy}, 32'd0);
        chk("async reset Done", {31'd0, bus.Done}, 32'd0);
        chk("async reset Result", {16'd0, bus.Result}, 32'd0);
        chk("async reset Adder", {15'd0, bus.AdderDataA, bus.AdderDataB, bus.AdderCarryIn}, 32'd0);
        repeat (2) @(posedge Clock); #3;
        nReset = 1'b1;
        repeat (3) @(posedge Clock); #1;
        req(16'h12F0, 8'h20, 16'h1310, 1'b1, 3);

        repeat (4) @(posedge Clock); #1;
        while (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk("missing Done", 32'd0, {16'd0, e.res});
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
